// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one sram-like port between inst fetch and data requesters
module sram_bus_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} lock_e;

   lock_e                      lock_q, lock_d;
   logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;   // 0 = inst, 1 = data
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [STV_W-1:0]           starve_q, starve_d;

   logic grant_data;
   logic full;
   logic xfer;
   logic pop;
   logic head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Grant selection: a locked side keeps the port until accepted; otherwise data wins unless inst is starving
   always_comb begin
      grant_data = 1'b1;
      if (!reset) begin
         case (lock_q)
            LOCK_I:  grant_data = 1'b0;
            LOCK_D:  grant_data = 1'b1;
            default: begin
               if (data_req && !(inst_req && starve_q == STV_MAX)) grant_data = 1'b1;
               else if (inst_req)                                  grant_data = 1'b0;
               else                                                grant_data = 1'b1;
            end
         endcase
      end
   end

   // Zero-latency request pass-through and response routing
   always_comb begin
      full         = (count_q == CNT_MAX);
      mem_req      = (grant_data ? data_req : inst_req) & ~full & ~reset;
      xfer         = mem_req & mem_addr_ok;
      inst_addr_ok = xfer & ~grant_data;
      data_addr_ok = xfer & grant_data;
      mem_wr       = grant_data ? data_wr    : inst_wr;
      mem_size     = grant_data ? data_size  : inst_size;
      mem_addr     = grant_data ? data_addr  : inst_addr;
      mem_wstrb    = grant_data ? data_wstrb : inst_wstrb;
      mem_wdata    = grant_data ? data_wdata : inst_wdata;
      // A response with nothing outstanding is stray and dropped
      pop          = mem_data_ok & (count_q != '0) & ~reset;
      head         = owner_q[rd_ptr_q];
      inst_data_ok = pop & ~head;
      data_data_ok = pop & head;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
   end

   // Next state for lock, owner FIFO, occupancy and fairness counter
   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;

      case (lock_q)
         IDLE: begin
            if (mem_req && !mem_addr_ok) lock_d = grant_data ? LOCK_D : LOCK_I;
         end
         LOCK_I, LOCK_D: begin
            if (xfer) lock_d = IDLE;
         end
         default: lock_d = IDLE;
      endcase

      if (xfer) begin
         owner_d[wr_ptr_q] = grant_data;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

      case ({xfer, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (!inst_req)                            starve_d = '0;
      else if (xfer && !grant_data)             starve_d = '0;
      else if (xfer && starve_q != STV_MAX)     starve_d = starve_q + STV_W'(1);
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q   <= IDLE;
         owner_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

   localparam int MAXO  = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic [3:0]  inst_wstrb;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of owners in request order, who is holding the port, fairness count
   int m_q[$];
   int m_held = -1;
   int m_starve = 0;
   int g;
   bit e_full, e_req, e_acc, e_pop, e_head;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_mem_req", mem_req, 0);
         chk("rst_iaok", inst_addr_ok, 0);
         chk("rst_daok", data_addr_ok, 0);
         chk("rst_idok", inst_data_ok, 0);
         chk("rst_ddok", data_data_ok, 0);
         chk("rst_mem_addr", mem_addr, data_addr);
         m_q.delete();
         m_held = -1;
         m_starve = 0;
      end else begin
         e_full = (m_q.size() == MAXO);
         if (m_held >= 0)                                   g = m_held;
         else if (data_req && !(inst_req && m_starve == LIMIT)) g = 1;
         else if (inst_req)                                 g = 0;
         else                                               g = 1;
         e_req  = ((g == 1) ? data_req : inst_req) && !e_full;
         e_acc  = e_req && mem_addr_ok;
         e_pop  = mem_data_ok && (m_q.size() > 0);
         e_head = (m_q.size() > 0) ? (m_q[0] == 1) : 1'b0;
         chk("m_mem_req", mem_req, e_req);
         chk("m_iaok", inst_addr_ok, e_acc && g == 0);
         chk("m_daok", data_addr_ok, e_acc && g == 1);
         chk("m_idok", inst_data_ok, e_pop && !e_head);
         chk("m_ddok", data_data_ok, e_pop && e_head);
         chk("m_irdata", inst_rdata, mem_rdata);
         chk("m_drdata", data_rdata, mem_rdata);
         if (e_req) begin
            chk("m_mem_addr",  mem_addr,  (g == 1) ? data_addr  : inst_addr);
            chk("m_mem_wr",    mem_wr,    (g == 1) ? data_wr    : inst_wr);
            chk("m_mem_size",  mem_size,  (g == 1) ? data_size  : inst_size);
            chk("m_mem_wstrb", mem_wstrb, (g == 1) ? data_wstrb : inst_wstrb);
            chk("m_mem_wdata", mem_wdata, (g == 1) ? data_wdata : inst_wdata);
         end
         if (e_pop) void'(m_q.pop_front());
         if (e_acc) m_q.push_back(g);
         if (e_req && !mem_addr_ok) m_held = g;
         else if (e_acc)            m_held = -1;
         if (!inst_req)                        m_starve = 0;
         else if (e_acc && g == 0)             m_starve = 0;
         else if (e_acc && m_starve < LIMIT)   m_starve++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
   endtask

   logic [9:0] glog;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
      data_wr = 0; data_size = 2; data_addr = 32'h1234_5678; data_wstrb = 0; data_wdata = 0;
      mem_rdata = 0;
      idle_in();
      data_req = 1; mem_addr_ok = 1;
      repeat (2) cyc();
      #1;
      chk("reset_mem_req", mem_req, 0);
      chk("reset_daok", data_addr_ok, 0);
      chk("reset_mem_addr", mem_addr, 32'h1234_5678);
      cyc(); reset = 0; idle_in();

      // single inst read
      cyc(); inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
      #1; chk("t1_iaok", inst_addr_ok, 1); chk("t1_maddr", mem_addr, 32'hBFC0_0000);
      cyc(); idle_in();
      #1; chk("t1_idok_c1", inst_data_ok, 0);
      cyc(); mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
      #1; chk("t1_idok", inst_data_ok, 1); chk("t1_rdata", inst_rdata, 32'h3C08_0001);
      chk("t1_ddok", data_data_ok, 0);
      cyc(); idle_in();

      // simultaneous requests: data first
      cyc(); inst_req = 1; inst_addr = 32'h0000_1000;
      data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'b0011;
      data_wdata = 32'hCAFE_F00D; mem_addr_ok = 1;
      #1; chk("t2_daok", data_addr_ok, 1); chk("t2_iaok0", inst_addr_ok, 0);
      chk("t2_maddr", mem_addr, 32'h8000_0010); chk("t2_wstrb", mem_wstrb, 4'b0011);
      cyc(); data_req = 0; data_wr = 0;
      #1; chk("t2_iaok", inst_addr_ok, 1); chk("t2_maddr_i", mem_addr, 32'h0000_1000);
      cyc(); idle_in(); mem_data_ok = 1; mem_rdata = 32'h11;
      #1; chk("t2_ddok", data_data_ok, 1); chk("t2_idok0", inst_data_ok, 0);
      cyc(); mem_rdata = 32'h22;
      #1; chk("t2_idok", inst_data_ok, 1); chk("t2_ird", inst_rdata, 32'h22);
      cyc(); idle_in();

      // lock: data stays presented while not accepted
      cyc(); data_req = 1; data_addr = 32'h8000_0100;
      #1; chk("t3_maddr0", mem_addr, 32'h8000_0100); chk("t3_daok0", data_addr_ok, 0);
      cyc(); inst_req = 1; inst_addr = 32'h0000_2000;
      #1; chk("t3_maddr1", mem_addr, 32'h8000_0100); chk("t3_iaok1", inst_addr_ok, 0);
      cyc();
      #1; chk("t3_maddr2", mem_addr, 32'h8000_0100);
      cyc(); mem_addr_ok = 1;
      #1; chk("t3_daok", data_addr_ok, 1); chk("t3_iaok3", inst_addr_ok, 0);
      cyc(); data_req = 0;
      #1; chk("t3_iaok", inst_addr_ok, 1); chk("t3_maddr_i", mem_addr, 32'h0000_2000);
      cyc(); idle_in(); mem_data_ok = 1;
      #1; chk("t3_ddok", data_data_ok, 1);
      cyc();
      #1; chk("t3_idok", inst_data_ok, 1);
      cyc(); idle_in();

      // full, pop frees a slot, push+pop
      cyc(); data_req = 1; data_addr = 32'hA0; mem_addr_ok = 1;
      #1; chk("t4_a", data_addr_ok, 1);
      cyc(); data_addr = 32'hA4;
      #1; chk("t4_b", data_addr_ok, 1);
      cyc(); data_addr = 32'hA8;
      #1; chk("t4_full_req", mem_req, 0); chk("t4_full_aok", data_addr_ok, 0);
      cyc(); mem_data_ok = 1;
      #1; chk("t4_pop_req", mem_req, 0); chk("t4_pop_ddok", data_data_ok, 1);
      cyc(); mem_data_ok = 0;
      #1; chk("t4_after_pop", data_addr_ok, 1);
      cyc(); data_addr = 32'hAC; mem_data_ok = 1;
      #1; chk("t4_f_req", mem_req, 0); chk("t4_f_ddok", data_data_ok, 1);
      cyc();
      #1; chk("t4_pp_aok", data_addr_ok, 1); chk("t4_pp_ddok", data_data_ok, 1);
      cyc(); data_addr = 32'hB0; mem_data_ok = 0;
      #1; chk("t4_h", data_addr_ok, 1);
      cyc(); data_addr = 32'hB4;
      #1; chk("t4_full2", mem_req, 0);
      cyc(); idle_in(); mem_data_ok = 1;
      #1; chk("t4_d1", data_data_ok, 1);
      cyc();
      #1; chk("t4_d2", data_data_ok, 1);
      cyc();
      #1; chk("t4_stray_d", data_data_ok, 0); chk("t4_stray_i", inst_data_ok, 0);
      cyc(); idle_in();

      // starvation
      glog = '0;
      cyc(); inst_req = 1; inst_addr = 32'h3000; data_req = 1; data_addr = 32'hD0;
      mem_addr_ok = 1; mem_data_ok = 1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         #1;
         chk("t5_one_grant", inst_addr_ok ^ data_addr_ok, 1);
         glog = {glog[8:0], data_addr_ok};
      end
      chk("t5_pattern", glog, 10'b1111011110);
      cyc(); idle_in(); mem_data_ok = 1;
      #1; chk("t5_drain", inst_data_ok, 1);
      cyc(); idle_in();

      // asynchronous reset mid-flight
      cyc(); data_req = 1; data_addr = 32'hC0; data_wr = 0; mem_addr_ok = 1;
      #1; chk("t6_daok", data_addr_ok, 1);
      cyc(); data_req = 0; inst_req = 1; inst_addr = 32'hD0;
      #1; chk("t6_iaok", inst_addr_ok, 1);
      cyc(); inst_req = 0; data_req = 1; data_addr = 32'hC4; mem_data_ok = 1; mem_rdata = 32'h55;
      #1; chk("t6_ddok_pre", data_data_ok, 1);
      #1; reset = 1;
      #1; chk("t6_rst_req", mem_req, 0); chk("t6_rst_ddok", data_data_ok, 0);
      chk("t6_rst_daok", data_addr_ok, 0); chk("t6_rst_idok", inst_data_ok, 0);
      cyc(); idle_in();
      cyc(); reset = 0; mem_data_ok = 1;
      #1; chk("t6_stray_d", data_data_ok, 0); chk("t6_stray_i", inst_data_ok, 0);
      cyc(); idle_in(); data_req = 1; data_addr = 32'hE0; mem_addr_ok = 1;
      #1; chk("t6_post_aok", data_addr_ok, 1);
      cyc(); idle_in(); mem_data_ok = 1; mem_rdata = 32'hAA;
      #1; chk("t6_post_ddok", data_data_ok, 1); chk("t6_post_rd", data_rdata, 32'hAA);
      cyc(); idle_in();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
